product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
// - Downstream stage of the 8x8 radix-4 Booth/Dadda multiplier: consumes its 16-bit unsigned product.
// - Sums a stream of products into a wide accumulator (dot-product / MAC reduction) and emits one result per group.
// - Valid/ready on both sides. A group closes on i_last or after MAX_TERMS terms.
// PARAMETERS
// - PRODW      16  product width; matches the multiplier's o_result
// - ACCW       24  accumulator width; ACCW >= PRODW
// - MAX_TERMS  16  max terms per group; count width CNTW = $clog2(MAX_TERMS+1)
// PORTS
// - i_clk       in   1          clock; everything sampled on rising edge
// - i_rst_n     in   1          synchronous, active-low reset
// - i_valid     in   1          product valid
// - o_ready     out  1          accumulator can accept a product
// - i_product   in   PRODW      unsigned product from the multiplier
// - i_last      in   1          qualifies i_valid: this term closes the group
// - i_clear     in   1          abort current group, discard partial sum
// - o_valid     out  1          group result valid
// - i_ready     in   1          downstream accepts result
// - o_acc       out  ACCW       group sum
// - o_count     out  CNTW       number of terms in the group
// - o_overflow  out  1          a carry out of ACCW occurred within this group
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
// - Reset (i_rst_n=0 at an edge): state=IDLE, acc=0, count=0, o_valid=0, o_overflow=0. o_ready=1 one cycle after reset is released.
// - FSM states: IDLE (count==0), ACCUM (0<count<MAX_TERMS), HOLD (result pending).
// - Input accept = i_valid & o_ready. o_ready = (state != HOLD), registered state only; no combinational path from i_ready.
// - On accept: sum = acc + zero-extended i_product; count+1.
//   - No close: go to ACCUM.
//   - Close (i_last=1 or count+1==MAX_TERMS): go to HOLD.
//   - A group closed by count without i_last is reported identically.
// - Latency: one cycle from the closing accept to o_valid=1, with o_acc=final sum and o_count=term count.
// - HOLD: o_valid=1, o_acc/o_count/o_overflow held stable until i_ready=1.
//   - On that edge: acc=0, count=0, overflow=0, go to IDLE; o_ready=1 in the next cycle.
//   - A product cannot be accepted in the same cycle the result is consumed.
// - Overflow: carry out of bit ACCW-1 in any accumulate sets o_overflow (sticky within the group). Default behaviour is modular wrap.
// - i_clear in IDLE/ACCUM: acc=0, count=0, overflow=0.
//   - If an accept occurs in the same cycle, clear has priority over the old sum: acc=i_product, count=1.
//   - That product still closes the group if i_last=1.
// - i_clear in HOLD: ignored; a pending result is never destroyed.
// - i_valid with o_ready=0: no state change. Upstream must hold the product (AXI-style).
// - i_last and i_product are don't-care when i_valid=0.
// CONFIGURATION
// - PRODUCT_ACC_SATURATE_EN defined: on carry out, acc clamps to 2^ACCW-1 and stays clamped for the rest of the group. o_overflow is still set.
// - Macro not defined: modular wrap (acc = sum mod 2^ACCW). No saturation logic is synthesised.
// TESTING
// - Reset: hold i_rst_n=0 3 cycles -> o_valid=0, o_acc=0, o_count=0, o_overflow=0; o_ready=1 after release.
// - 3 products 65025 (255*255), back-to-back, last on 3rd -> next cycle o_valid=1, o_acc=195075, o_count=3, o_overflow=0.
// - 16 products of 1, i_last never set -> group closes on 16th, o_acc=16, o_count=16; 17th i_valid stalls (o_ready=0).
// - Backpressure: result pending with i_ready=0 for 5 cycles -> o_acc stable, o_ready=0, i_clear ignored.
//   - Then i_ready=1 -> IDLE, and the next group starts from 0.
// - ACCW=17, 3x65025:
//   - No macro -> o_acc=64003, o_overflow=1.
//   - With PRODUCT_ACC_SATURATE_EN -> o_acc=131071, o_overflow=1.
// - Mid-group: 2 terms of 100, then i_clear with accepted 7 and i_last -> o_acc=7, o_count=1.
//   - i_rst_n=0 mid-group -> all outputs return to reset values.

Source files
------------

// File: rtl/product_accumulator.sv
// ============================================================================
// product_accumulator: sums a stream of unsigned products into one result per group.
// Rev 1.0. Clamp on overflow instead of wrap when PRODUCT_ACC_SATURATE_EN is defined.
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int PRODW     = 16,
  parameter int ACCW      = 24,
  parameter int MAX_TERMS = 16,
  parameter int CNTW      = $clog2(MAX_TERMS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PRODW-1:0] i_product,
  input  logic             i_last,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACCW-1:0]  o_acc,
  output logic [CNTW-1:0]  o_count,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] C_MAX_CNT = CNTW'(MAX_TERMS);

  state_t            r_state;
  logic [ACCW-1:0]   r_acc;
  logic [CNTW-1:0]   r_count;
  logic              r_ovf;

  state_t            w_state_nxt;
  logic [ACCW-1:0]   w_acc_nxt;
  logic [CNTW-1:0]   w_count_nxt;
  logic              w_ovf_nxt;

  logic              w_accept;
  logic [ACCW-1:0]   w_base_acc;
  logic [CNTW-1:0]   w_base_cnt;
  logic              w_base_ovf;
  logic [ACCW:0]     w_sum;
  logic              w_carry;
  logic [ACCW-1:0]   w_acc_add;
  logic [CNTW-1:0]   w_cnt_inc;
  logic              w_close;

  assign o_ready  = (r_state != HOLD);
  assign w_accept = i_valid & o_ready;

  // A clear coinciding with an accept starts the group fresh with this product.
  assign w_base_acc = i_clear ? '0 : r_acc;
  assign w_base_cnt = i_clear ? '0 : r_count;
  assign w_base_ovf = i_clear ? 1'b0 : r_ovf;

  assign w_sum     = {1'b0, w_base_acc} + (ACCW+1)'(i_product);
  assign w_carry   = w_sum[ACCW];
  assign w_cnt_inc = w_base_cnt + CNTW'(1);
  assign w_close   = i_last | (w_cnt_inc == C_MAX_CNT);

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once clamped, any further nonzero term carries again, so the clamp persists.
  assign w_acc_add = w_carry ? {ACCW{1'b1}} : w_sum[ACCW-1:0];
`else
  assign w_acc_add = w_sum[ACCW-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      HOLD: begin
        if (i_ready) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_acc_add;
          w_count_nxt = w_cnt_inc;
          w_ovf_nxt   = w_base_ovf | w_carry;
          w_state_nxt = w_close ? HOLD : ACCUM;
        end else if (i_clear) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
        w_count_nxt = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_valid    = (r_state == HOLD);
  assign o_acc      = r_acc;
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// tb_product_accumulator: directed self-checking bench for product_accumulator.
// Rev 1.0. Second instance uses ACCW=17 for the overflow / saturation case.
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  localparam int PRODW = 16;
  localparam int ACCW  = 24;
  localparam int MAXT  = 16;
  localparam int CNTW  = $clog2(MAXT + 1);

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic [PRODW-1:0] i_product;
  logic             i_last;
  logic             i_clear;
  logic             i_ready;

  logic             w_ready,  w_ready2;
  logic             w_valid,  w_valid2;
  logic [ACCW-1:0]  w_acc;
  logic [16:0]      w_acc2;
  logic [CNTW-1:0]  w_count,  w_count2;
  logic             w_ovf,    w_ovf2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  product_accumulator #(.PRODW(PRODW), .ACCW(ACCW), .MAX_TERMS(MAXT)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(w_ready),
    .i_product(i_product), .i_last(i_last), .i_clear(i_clear),
    .o_valid(w_valid), .i_ready(i_ready), .o_acc(w_acc), .o_count(w_count),
    .o_overflow(w_ovf)
  );

  product_accumulator #(.PRODW(PRODW), .ACCW(17), .MAX_TERMS(MAXT)) u_dut17 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(w_ready2),
    .i_product(i_product), .i_last(i_last), .i_clear(i_clear),
    .o_valid(w_valid2), .i_ready(i_ready), .o_acc(w_acc2), .o_count(w_count2),
    .o_overflow(w_ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_product = '0; i_last = 1'b0; i_clear = 1'b0;
  endtask

  task automatic send(input logic [PRODW-1:0] p, input logic last, input logic clr);
    i_valid = 1'b1; i_product = p; i_last = last; i_clear = clr;
    tick();
    idle_inputs();
  endtask

  task automatic consume();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_ready = 1'b0;
    idle_inputs();
    #1;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_valid", 32'(w_valid), 0);
    check("rst_acc",   32'(w_acc),   0);
    check("rst_count", 32'(w_count), 0);
    check("rst_ovf",   32'(w_ovf),   0);
    i_rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(w_ready), 1);

    // Three back-to-back 255*255 products closed by i_last
    send(16'd65025, 1'b0, 1'b0);
    send(16'd65025, 1'b0, 1'b0);
    send(16'd65025, 1'b1, 1'b0);
    check("g3_valid", 32'(w_valid), 1);
    check("g3_acc",   32'(w_acc),   195075);
    check("g3_count", 32'(w_count), 3);
    check("g3_ovf",   32'(w_ovf),   0);
    check("g3_ready", 32'(w_ready), 0);
    consume();
    check("g3_done_valid", 32'(w_valid), 0);
    check("g3_done_ready", 32'(w_ready), 1);

    // Sixteen ones, closed by the term limit
    for (int k = 0; k < MAXT; k++) send(16'd1, 1'b0, 1'b0);
    check("g16_valid", 32'(w_valid), 1);
    check("g16_acc",   32'(w_acc),   16);
    check("g16_count", 32'(w_count), 16);
    check("g16_ready", 32'(w_ready), 0);

    // 17th product stalls; clear ignored while the result waits
    i_valid = 1'b1; i_product = 16'd5; i_clear = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_acc",   32'(w_acc),   16);
      check("bp_count", 32'(w_count), 16);
      check("bp_valid", 32'(w_valid), 1);
      check("bp_ready", 32'(w_ready), 0);
    end
    idle_inputs();
    consume();
    check("bp_idle_valid", 32'(w_valid), 0);
    send(16'd3, 1'b1, 1'b0);
    check("bp_next_acc",   32'(w_acc),   3);
    check("bp_next_count", 32'(w_count), 1);
    consume();

    // Overflow on a 17-bit accumulator
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    send(16'd65025, 1'b0, 1'b0);
    send(16'd65025, 1'b0, 1'b0);
    send(16'd65025, 1'b1, 1'b0);
    check("a17_valid", 32'(w_valid2), 1);
`ifdef PRODUCT_ACC_SATURATE_EN
    check("a17_acc",   32'(w_acc2),   131071);
`else
    check("a17_acc",   32'(w_acc2),   64003);
`endif
    check("a17_ovf",   32'(w_ovf2),   1);
    check("a17_count", 32'(w_count2), 3);
    check("a24_noovf", 32'(w_ovf),    0);
    consume();
    check("a17_ovf_cleared", 32'(w_ovf2), 0);

    // Clear together with an accepted closing term
    send(16'd100, 1'b0, 1'b0);
    send(16'd100, 1'b0, 1'b0);
    send(16'd7,   1'b1, 1'b1);
    check("clr_valid", 32'(w_valid), 1);
    check("clr_acc",   32'(w_acc),   7);
    check("clr_count", 32'(w_count), 1);
    consume();

    // Clear alone in ACCUM discards the partial sum
    send(16'd20, 1'b0, 1'b0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    send(16'd4, 1'b1, 1'b0);
    check("clr2_acc",   32'(w_acc),   4);
    check("clr2_count", 32'(w_count), 1);
    consume();

    // Reset mid-group
    send(16'd50, 1'b0, 1'b0);
    send(16'd50, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    tick();
    check("mrst_valid", 32'(w_valid), 0);
    check("mrst_acc",   32'(w_acc),   0);
    check("mrst_count", 32'(w_count), 0);
    check("mrst_ovf",   32'(w_ovf),   0);
    i_rst_n = 1'b1;
    tick();
    check("mrst_ready", 32'(w_ready), 1);
    send(16'd9, 1'b1, 1'b0);
    check("mrst_next_acc",   32'(w_acc),   9);
    check("mrst_next_count", 32'(w_count), 1);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
